// File: rtl/prf_pkg.sv
// Shared types, constants and the write-port priority encoder for the prf_multiport register file.
package prf_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } dbg_state_t;

  localparam int PRF_DBG_BYTE  = 8;
  localparam int PRF_MAX_WPORT = 16;
  localparam int PRF_MAX_INDEX = 16;
  localparam int PRF_SEL_W     = $clog2(PRF_MAX_WPORT);

  typedef struct packed {
    logic                 hit;
    logic [PRF_SEL_W-1:0] idx;
  } prf_sel_t;

  // Callers zero-pad unused ports with wr_vld low. The last match in the loop
  // is kept, so the highest-index port wins.
  function automatic prf_sel_t prf_wr_sel(
    input logic [PRF_MAX_INDEX-1:0]               addr,
    input logic [PRF_MAX_WPORT*PRF_MAX_INDEX-1:0] wr_addr,
    input logic [PRF_MAX_WPORT-1:0]               wr_vld
  );
    prf_sel_t sel;
    sel = '0;
    for (int i = 0; i < PRF_MAX_WPORT; i++) begin
      if (wr_vld[i] && (wr_addr[i*PRF_MAX_INDEX +: PRF_MAX_INDEX] == addr)) begin
        sel.hit = 1'b1;
        sel.idx = PRF_SEL_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/prf_dbg_engine.sv
// Byte-serial debug engine: stages a word byte by byte and commits it through one internal write port.
// It also returns single bytes of the register file on a read strobe.
module prf_dbg_engine
  import prf_pkg::*;
#(
  parameter int INDEX    = 7,
  parameter int WIDTH    = 64,
  parameter int BYTE_LOG = $clog2(WIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INDEX+BYTE_LOG-1:0] dbg_addr_i,
  input  logic [7:0]                dbg_wr_data_i,
  input  logic                      dbg_wr_en_i,
  input  logic                      dbg_rd_en_i,
  input  logic [WIDTH-1:0]          rd_word_i,
  input  logic                      conflict_i,
  output logic [INDEX-1:0]          cw_addr_o,
  output logic [WIDTH-1:0]          cw_data_o,
  output logic                      cw_we_o,
  output logic [7:0]                rd_data_o,
  output logic                      rd_valid_o,
  output logic                      busy_o
);

  localparam int NBYTES = WIDTH / PRF_DBG_BYTE;

  dbg_state_t          state_q, state_d;
  logic [WIDTH-1:0]    stage_q, stage_d;
  logic [INDEX-1:0]    entry_q, entry_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [INDEX-1:0]    req_entry;
  logic [BYTE_LOG-1:0] req_byte;
  logic                take_wr;
  logic                take_rd;

  assign req_entry = dbg_addr_i[BYTE_LOG +: INDEX];
  assign req_byte  = dbg_addr_i[BYTE_LOG-1:0];

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    take_wr    = (state_q == IDLE) && dbg_wr_en_i;
    take_rd    = (state_q == IDLE) && dbg_rd_en_i && !dbg_wr_en_i;
    state_d    = state_q;
    stage_d    = stage_q;
    entry_d    = entry_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = take_rd;
    case (state_q)
      IDLE: begin
        if (take_wr) begin
          stage_d[req_byte*PRF_DBG_BYTE +: PRF_DBG_BYTE] = dbg_wr_data_i;
          if (req_byte == BYTE_LOG'(NBYTES - 1)) begin
            entry_d = req_entry;
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        // A pipeline write to the same entry always wins; the commit retries next cycle.
        if (!conflict_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (take_rd) rd_data_d = rd_word_i[req_byte*PRF_DBG_BYTE +: PRF_DBG_BYTE];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      entry_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      entry_q    <= entry_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign cw_addr_o  = entry_q;
  assign cw_data_o  = stage_q;
  assign cw_we_o    = (state_q == COMMIT) && !conflict_i;
  assign busy_o     = (state_q == COMMIT);
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/prf_multiport.sv
// prf_multiport: flop-array physical register file with gated read/write lanes and a debug port.
// Define PRF_WR_BYPASS_EN to forward same-cycle pipeline write data to matching reads.
module prf_multiport
  import prf_pkg::*;
#(
  parameter int WPORT    = 4,
  parameter int RPORT    = 2 * WPORT,
  parameter int DEPTH    = 96,
  parameter int INDEX    = 7,
  parameter int WIDTH    = 64,
  parameter int BYTE_LOG = $clog2(WIDTH / 8)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WPORT-1:0]          laneActive_i,
  input  logic [RPORT*INDEX-1:0]    rdAddr_i,
  output logic [RPORT*WIDTH-1:0]    rdData_o,
  input  logic [WPORT*INDEX-1:0]    wrAddr_i,
  input  logic [WPORT*WIDTH-1:0]    wrData_i,
  input  logic [WPORT-1:0]          wrEn_i,
  input  logic [INDEX+BYTE_LOG-1:0] dbgAddr_i,
  input  logic [7:0]                dbgWrData_i,
  input  logic                      dbgWrEn_i,
  input  logic                      dbgRdEn_i,
  output logic [7:0]                dbgRdData_o,
  output logic                      dbgRdValid_o,
  output logic                      dbgBusy_o
);

  function automatic logic in_range(input logic [INDEX-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  prf_sel_t         ent_sel [DEPTH];

  logic [INDEX-1:0] rd_addr [RPORT];
  logic [INDEX-1:0] wr_addr [WPORT];
  logic [WIDTH-1:0] wr_data [WPORT];
  logic [WPORT-1:0] wr_vld;
  logic [PRF_MAX_WPORT*PRF_MAX_INDEX-1:0] wr_addr_pad;
  logic [PRF_MAX_WPORT-1:0]               wr_vld_pad;

  logic [INDEX-1:0] dbg_entry;
  logic [WIDTH-1:0] dbg_rd_word;
  logic [INDEX-1:0] dbg_waddr;
  logic [WIDTH-1:0] dbg_wdata;
  logic             dbg_we;
  logic             dbg_conflict;

  always_comb begin
    wr_addr_pad = '0;
    wr_vld_pad  = '0;
    for (int k = 0; k < WPORT; k++) begin
      wr_addr[k] = wrAddr_i[k*INDEX +: INDEX];
      wr_data[k] = wrData_i[k*WIDTH +: WIDTH];
      wr_vld[k]  = wrEn_i[k] && laneActive_i[k] && in_range(wr_addr[k]);
      wr_addr_pad[k*PRF_MAX_INDEX +: PRF_MAX_INDEX] = PRF_MAX_INDEX'(wr_addr[k]);
      wr_vld_pad[k] = wr_vld[k];
    end
    for (int p = 0; p < RPORT; p++) begin
      rd_addr[p] = rdAddr_i[p*INDEX +: INDEX];
    end
  end

  // Per-entry write decode; it also supplies the debug engine's conflict check.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      ent_sel[e] = prf_wr_sel(PRF_MAX_INDEX'(e), wr_addr_pad, wr_vld_pad);
    end
  end

  assign dbg_conflict = in_range(dbg_waddr) ? ent_sel[dbg_waddr].hit : 1'b0;

  always_comb begin
    mem_d = mem_q;
    if (dbg_we && in_range(dbg_waddr)) mem_d[dbg_waddr] = dbg_wdata;
    for (int e = 0; e < DEPTH; e++) begin
      for (int k = 0; k < WPORT; k++) begin
        if (ent_sel[e].hit && (ent_sel[e].idx == PRF_SEL_W'(k))) mem_d[e] = wr_data[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: this storage is reset on purpose; every entry must read 0 after reset, so the array gets a reset loop.
    if (!reset) begin
      for (int e = 0; e < DEPTH; e++) mem_q[e] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

`ifdef PRF_WR_BYPASS_EN
  prf_sel_t byp_sel [RPORT];
`endif

  always_comb begin
    rdData_o = '0;
    for (int p = 0; p < RPORT; p++) begin
`ifdef PRF_WR_BYPASS_EN
      byp_sel[p] = prf_wr_sel(PRF_MAX_INDEX'(rd_addr[p]), wr_addr_pad, wr_vld_pad);
`endif
      if (laneActive_i[p/2] && in_range(rd_addr[p])) begin
        rdData_o[p*WIDTH +: WIDTH] = mem_q[rd_addr[p]];
`ifdef PRF_WR_BYPASS_EN
        for (int k = 0; k < WPORT; k++) begin
          if (byp_sel[p].hit && (byp_sel[p].idx == PRF_SEL_W'(k))) begin
            rdData_o[p*WIDTH +: WIDTH] = wr_data[k];
          end
        end
`endif
      end
    end
  end

  assign dbg_entry   = dbgAddr_i[BYTE_LOG +: INDEX];
  assign dbg_rd_word = in_range(dbg_entry) ? mem_q[dbg_entry] : '0;

  prf_dbg_engine #(
    .INDEX   (INDEX),
    .WIDTH   (WIDTH),
    .BYTE_LOG(BYTE_LOG)
  ) u_dbg (
    .clk          (clk),
    .rst_n        (reset),
    .dbg_addr_i   (dbgAddr_i),
    .dbg_wr_data_i(dbgWrData_i),
    .dbg_wr_en_i  (dbgWrEn_i),
    .dbg_rd_en_i  (dbgRdEn_i),
    .rd_word_i    (dbg_rd_word),
    .conflict_i   (dbg_conflict),
    .cw_addr_o    (dbg_waddr),
    .cw_data_o    (dbg_wdata),
    .cw_we_o      (dbg_we),
    .rd_data_o    (dbgRdData_o),
    .rd_valid_o   (dbgRdValid_o),
    .busy_o       (dbgBusy_o)
  );

endmodule

// File: doc/prf_multiport.md
# prf_multiport

Parametrised physical register file for the register-read stage: RPORT combinational read ports, WPORT clocked write ports, per-lane gating, optional same-cycle write-to-read forwarding, and a byte-serial debug engine. Writeback lanes drive the write ports; register-read lanes consume the read ports. The debug engine supports off-chip PRF inspection and patching through an 8-bit interface. It has its own commit state machine and backs off on conflicts with pipeline writes.

## Interface
- RPORT, 2*WPORT: number of read ports; read port 2k and read port 2k+1 belong to lane k.
- WPORT, 4: number of write ports, one per lane.
- DEPTH, 96: number of entries.
- INDEX, 7: address width; DEPTH <= 2**INDEX.
- WIDTH, 64: data width; must be a multiple of 8.
- BYTE_LOG, $clog2(WIDTH/8): byte-offset width of the debug address.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- laneActive_i  in  WPORT  lane enables; bit k gates write port k and read ports 2k and 2k+1.
- rdAddr_i  in  RPORT*INDEX  read addresses, flat-packed; port p occupies bits [p*INDEX +: INDEX].
- rdData_o  out  RPORT*WIDTH  read data, flat-packed.
- wrAddr_i  in  WPORT*INDEX  write addresses.
- wrData_i  in  WPORT*WIDTH  write data.
- wrEn_i  in  WPORT  write enables.
- dbgAddr_i  in  INDEX+BYTE_LOG  debug address; {entry, byte offset}.
- dbgWrData_i  in  8  debug write byte.
- dbgWrEn_i  in  1  debug byte write strobe.
- dbgRdEn_i  in  1  debug byte read strobe.
- dbgRdData_o  out  8  debug read byte; registered.
- dbgRdValid_o  out  1  one-cycle pulse qualifying dbgRdData_o.
- dbgBusy_o  out  1  high while a debug commit is pending; debug strobes are ignored while high.

## Operation
- Storage is a flop array, DEPTH x WIDTH; reset clears every entry to 0.
- Read (combinational): rdData[p] = mem[rdAddr[p]].
  - If lane p/2 is inactive, rdData[p] = 0.
  - If rdAddr >= DEPTH, rdData[p] = 0.
- Write: write port k commits at the edge when wrEn[k] and laneActive[k] are both set and wrAddr[k] < DEPTH.
- Write collision (several ports, same address, same cycle): the highest-index port wins. No error is flagged.
- Debug write: each dbgWrEn_i strobe stores dbgWrData_i into stage[byte*8 +: 8], a WIDTH-bit staging register.
  - A strobe to byte offset WIDTH/8-1 also latches the entry address and moves the state machine to COMMIT.
  - That final byte is merged into the committed word.
- Debug commit: in COMMIT, the staged word is written to the latched entry.
  - If any enabled pipeline write targets the same entry in that cycle, the debug commit is retried the next cycle. Pipeline writes always win.
- Debug read: a dbgRdEn_i strobe registers the addressed byte of mem[entry], sampled pre-edge. dbgRdValid_o pulses on the next cycle.
- Simultaneous debug read and debug write strobes: the write is taken and the read is ignored; dbgRdValid_o stays low.
- State machine:
  - IDLE -> COMMIT on a final-byte write.
  - COMMIT -> IDLE when the commit succeeds; COMMIT -> COMMIT on conflict.
  - dbgBusy_o = (state == COMMIT).
- Reset values: state IDLE, stage 0, dbgRdData_o 0, dbgRdValid_o 0, dbgBusy_o 0.
- Reset asserted mid-commit: the commit is abandoned and the storage is cleared.

## Timing
- Read-to-data latency: 0 cycles (combinational).
- Write-to-visible: 1 cycle. With PRF_WR_BYPASS_EN, 0 cycles.
- Debug read latency: 1 cycle from strobe to dbgRdValid_o.
- Debug commit: a conflict-free commit lands 1 edge after the final-byte strobe. Each conflicting cycle adds one cycle.
- Reset is asynchronous; release is synchronised externally.

## Configuration
- PRF_WR_BYPASS_EN defined: a read returns the same-cycle write data on an address match with an enabled write port (highest-index port wins). Debug commits are never forwarded.
- PRF_WR_BYPASS_EN undefined: reads see pre-edge storage only; the writeback bypass network supplies forwarding.

## Structure
- Shared package (prf_pkg) holds the following; the remaining parameters stay local:
  - typedef dbg_state_t {IDLE, COMMIT};
  - constant PRF_DBG_BYTE = 8;
  - function prf_wr_sel: priority encoder returning the winning port index and hit for a given address.
- One sub-module, prf_dbg_engine, contains:
  - the staging register, the state machine, and conflict detection;
  - the read-byte register.
- prf_dbg_engine presents a single internal write port (address, data, we) to the array. Its conflict input comes from the array's write decode.

## Test plan
- Basic write/read: reset, then write port 0 writes 0xDEAD_BEEF_0000_0001 to entry 5. The next cycle, read port 3 at address 5 returns that value. Every other entry reads 0.
- Write collision: ports 1 and 3 both write entry 9, with 0x11 and 0x33. Entry 9 = 0x33.
- Lane gating: laneActive = 4'b1101 with a lane-1 write to entry 2. Entry 2 stays unchanged, and rdData[2] and rdData[3] read 0.
- Bypass: with PRF_WR_BYPASS_EN, a same-cycle write of 0x77 to entry 12 with read address 12 returns 0x77. Without the macro, the read returns the old value 0.
- Debug write with conflict: write bytes 0x01..0x08 to entry 20, offsets 0..7. In the commit cycle, pipeline port 2 writes 0xAA to entry 20.
  - Required: dbgBusy_o is high for 2 cycles, and entry 20 ends up 0x0807060504030201.
- Debug read: entry 20 = 0x0807060504030201, dbgRdEn_i at offset 1. One cycle later dbgRdData_o = 0x02 with dbgRdValid_o pulsed once. Asserting reset mid-COMMIT clears dbgBusy_o immediately.
